// File: rtl/row_col_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | row_col_product_accumulator                                                |
// | Streaming dot-product accumulator: LANES products per beat, one result per |
// | ROW_COL_SIZE products, signed/unsigned, wrap/saturate, sticky overflow.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module row_col_product_accumulator #(
  parameter int PRODUCT_WIDTH = 16,
  parameter int SUM_WIDTH     = 32,
  parameter int ROW_COL_SIZE  = 16,
  parameter int LANES         = 4,
  parameter int SIGNED        = 0,
  parameter int SATURATE      = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             abort,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*PRODUCT_WIDTH-1:0]   in_product,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SUM_WIDTH-1:0]             out_sum,
  output logic                             out_overflow
);

  localparam int c_beats = ROW_COL_SIZE / LANES;
  localparam int c_cnt_w = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int c_ext_w = SUM_WIDTH + $clog2(LANES) + 1;
  localparam bit c_signed = (SIGNED != 0);
  localparam bit c_saturate = (SATURATE != 0);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_beats - 1);
  localparam logic [SUM_WIDTH-1:0] c_sum_max =
    c_signed ? {1'b0, {(SUM_WIDTH-1){1'b1}}} : {SUM_WIDTH{1'b1}};
  localparam logic [SUM_WIDTH-1:0] c_sum_min =
    c_signed ? {1'b1, {(SUM_WIDTH-1){1'b0}}} : {SUM_WIDTH{1'b0}};

  logic [c_cnt_w-1:0]   r_cnt;
  logic [SUM_WIDTH-1:0] r_acc;
  logic                 r_ovf_acc;
  logic                 r_out_valid;
  logic [SUM_WIDTH-1:0] r_out_sum;
  logic                 r_out_overflow;

  logic [c_ext_w-1:0]           w_ext [LANES];
  logic [c_ext_w-1:0]           w_lane_sum;
  logic [c_ext_w-1:0]           w_acc_ext;
  logic [c_ext_w-1:0]           w_next;
  logic [c_ext_w-SUM_WIDTH:0]   w_top;
  logic                         w_ovf;
  logic                         w_ovf_acc;
  logic [SUM_WIDTH-1:0]         w_result;
  logic                         w_last;
  logic                         w_accept;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic w_sign;
      assign w_sign   = c_signed & in_product[(k+1)*PRODUCT_WIDTH-1];
      assign w_ext[k] = {{(c_ext_w-PRODUCT_WIDTH){w_sign}},
                         in_product[k*PRODUCT_WIDTH +: PRODUCT_WIDTH]};
    end
  endgenerate

  // Extended width guarantees the lane sum and acc + lane sum never wrap.
  always_comb begin
    w_lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      w_lane_sum = w_lane_sum + w_ext[k];
    end
  end

  assign w_acc_ext = {{(c_ext_w-SUM_WIDTH){c_signed & r_acc[SUM_WIDTH-1]}}, r_acc};
  assign w_next    = (r_cnt == '0) ? w_lane_sum : (w_acc_ext + w_lane_sum);
  assign w_top     = w_next[c_ext_w-1:SUM_WIDTH-1];

  // Signed fits when all bits from the sum MSB upward agree; unsigned when they are zero above it.
  assign w_ovf = c_signed ? !((w_top == '0) || (w_top == '1))
                          : (w_top[c_ext_w-SUM_WIDTH:1] != '0);

  always_comb begin
    w_result = w_next[SUM_WIDTH-1:0];
    if (w_ovf && c_saturate) begin
      w_result = (c_signed && w_next[c_ext_w-1]) ? c_sum_min : c_sum_max;
    end
  end

  assign w_ovf_acc = ((r_cnt == '0) ? 1'b0 : r_ovf_acc) | w_ovf;
  assign w_last    = (r_cnt == c_last);
  assign in_ready  = !rst && !abort && !(r_out_valid && !out_ready && w_last);
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_ovf_acc      <= 1'b0;
      r_out_valid    <= 1'b0;
      r_out_sum      <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      if (abort) begin
        r_cnt     <= '0;
        r_acc     <= '0;
        r_ovf_acc <= 1'b0;
      end else if (w_accept) begin
        r_acc     <= w_result;
        r_ovf_acc <= w_ovf_acc;
        r_cnt     <= w_last ? '0 : (r_cnt + c_cnt_w'(1));
      end
      // A pending result is untouched by abort; only consume or a new result changes it.
      if (w_accept && w_last) begin
        r_out_valid    <= 1'b1;
        r_out_sum      <= w_result;
        r_out_overflow <= w_ovf_acc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_overflow = r_out_overflow;

endmodule
`default_nettype wire

// File: tb/tb_row_col_product_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_row_col_product_accumulator                                             |
// | Four configurations share one stimulus stream; a per-dot arithmetic model  |
// | predicts every result, handshake and flag.                                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_row_col_product_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_product = '0;

  logic [3:0]  rdy, vld, ovf;
  logic [31:0] sum0;
  logic [15:0] sum1, sum2, sum3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // 0: unsigned wrap 32b, 1: signed saturate 16b, 2: signed wrap 16b, 3: unsigned saturate 16b
  row_col_product_accumulator #(.PRODUCT_WIDTH(16), .SUM_WIDTH(32), .ROW_COL_SIZE(16),
    .LANES(4), .SIGNED(0), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_product(in_product), .out_valid(vld[0]), .out_ready(out_ready),
    .out_sum(sum0), .out_overflow(ovf[0]));
  row_col_product_accumulator #(.PRODUCT_WIDTH(16), .SUM_WIDTH(16), .ROW_COL_SIZE(16),
    .LANES(4), .SIGNED(1), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_product(in_product), .out_valid(vld[1]), .out_ready(out_ready),
    .out_sum(sum1), .out_overflow(ovf[1]));
  row_col_product_accumulator #(.PRODUCT_WIDTH(16), .SUM_WIDTH(16), .ROW_COL_SIZE(16),
    .LANES(4), .SIGNED(1), .SATURATE(0)) u_dut2 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_product(in_product), .out_valid(vld[2]), .out_ready(out_ready),
    .out_sum(sum2), .out_overflow(ovf[2]));
  row_col_product_accumulator #(.PRODUCT_WIDTH(16), .SUM_WIDTH(16), .ROW_COL_SIZE(16),
    .LANES(4), .SIGNED(0), .SATURATE(1)) u_dut3 (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy[3]),
    .in_product(in_product), .out_valid(vld[3]), .out_ready(out_ready),
    .out_sum(sum3), .out_overflow(ovf[3]));

  int cfg_s   [4] = '{32, 16, 16, 16};
  bit cfg_sgn [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit cfg_sat [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  logic [15:0] cur [16];
  int          m_cnt = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_sum [4] = '{default: '0};
  bit          m_ovf [4] = '{default: 1'b0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Dot product of the 16 stored products with per-beat clamp or wrap.
  function automatic void ref_dot(input int s, input bit sgn, input bit sat,
                                  output logic [31:0] sum, output bit ov);
    longint modv, lo, hi, acc, ls, nxt;
    modv = longint'(1) << s;
    if (sgn) begin hi = (modv >> 1) - 1; lo = -(modv >> 1); end
    else     begin hi = modv - 1;        lo = 0;            end
    acc = 0;
    ov  = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ls = 0;
      for (int k = 0; k < 4; k++) begin
        if (sgn) ls += longint'($signed(cur[b*4+k]));
        else     ls += longint'(cur[b*4+k]);
      end
      nxt = (b == 0) ? ls : acc + ls;
      if (nxt > hi || nxt < lo) begin
        ov = 1'b1;
        if (sat) nxt = (nxt > hi) ? hi : lo;
        else begin
          nxt = nxt & (modv - 1);
          if (sgn && nxt > hi) nxt -= modv;
        end
      end
      acc = nxt;
    end
    sum = 32'(acc & (modv - 1));
  endfunction

  function automatic logic [63:0] dut_sum(input int i);
    case (i)
      0:       return {32'h0, sum0};
      1:       return {48'h0, sum1};
      2:       return {48'h0, sum2};
      default: return {48'h0, sum3};
    endcase
  endfunction

  task automatic cycle(input bit r, input bit a, input bit v, input bit ordy,
                       input logic [63:0] prod);
    bit exp_rdy, take, fin;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out_valid%0d", i), 64'(vld[i]), 64'(m_valid));
      check($sformatf("out_sum%0d", i), dut_sum(i), 64'(m_sum[i]));
      check($sformatf("out_overflow%0d", i), 64'(ovf[i]), 64'(m_ovf[i]));
    end
    rst = r; abort = a; in_valid = v; out_ready = ordy; in_product = prod;
    #1;
    exp_rdy = !r && !a && !(m_valid && !ordy && m_cnt == 3);
    for (int i = 0; i < 4; i++) check($sformatf("in_ready%0d", i), 64'(rdy[i]), 64'(exp_rdy));
    fin = 1'b0;
    take = v && exp_rdy;
    if (r) begin
      m_cnt = 0; m_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin m_sum[i] = '0; m_ovf[i] = 1'b0; end
    end else begin
      if (a) m_cnt = 0;
      else if (take) begin
        for (int k = 0; k < 4; k++) cur[m_cnt*4+k] = prod[k*16 +: 16];
        if (m_cnt == 3) begin
          fin = 1'b1;
          m_cnt = 0;
          for (int i = 0; i < 4; i++) ref_dot(cfg_s[i], cfg_sgn[i], cfg_sat[i], m_sum[i], m_ovf[i]);
        end else m_cnt++;
      end
      if (fin) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
    end
  endtask

  task automatic dot_const(input logic [15:0] val, input bit ordy);
    for (int b = 0; b < 4; b++) cycle(1'b0, 1'b0, 1'b1, ordy, {4{val}});
  endtask

  task automatic dot_ramp(input bit ordy);
    for (int b = 0; b < 4; b++)
      cycle(1'b0, 1'b0, 1'b1, ordy, {16'(b*4+4), 16'(b*4+3), 16'(b*4+2), 16'(b*4+1)});
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h7FFF;
      2:       return 16'h8000;
      3:       return 16'hFFFF;
      4:       return 16'($urandom_range(0, 15));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);

    dot_ramp(1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("ramp_sum", 64'(sum0), 64'd136);
    check("ramp_ovf", 64'(ovf[0]), 64'd0);
    repeat (3) dot_ramp(1'b1);

    dot_const(16'h7FFF, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("sat_max", 64'(sum1), 64'h7FFF);
    check("sat_max_ovf", 64'(ovf[1]), 64'd1);
    check("wrap_sum", 64'(sum2), 64'hFFF0);  // 16*0x7FFF mod 2^16
    check("wrap_ovf", 64'(ovf[2]), 64'd1);
    dot_const(16'h8000, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("sat_min", 64'(sum1), 64'h8000);
    check("sat_min_ovf", 64'(ovf[1]), 64'd1);
    dot_const(16'h0001, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("clean_ovf", 64'(ovf[2]), 64'd0);

    // Backpressure: result held while the next dot stalls on its last beat.
    dot_ramp(1'b0);
    for (int b = 0; b < 3; b++) cycle(1'b0, 1'b0, 1'b1, 1'b0, {4{16'h0002}});
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, {4{16'h0002}});
    check("stall_hold", 64'(sum0), 64'd136);
    check("stall_ready", 64'(rdy[0]), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, {4{16'h0002}});
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("stall_new", 64'(sum0), 64'd32);

    // Abort with a pending result.
    dot_ramp(1'b0);
    for (int b = 0; b < 2; b++) cycle(1'b0, 1'b0, 1'b1, 1'b0, {4{16'h0005}});
    cycle(1'b0, 1'b1, 1'b1, 1'b0, {4{16'h0005}});
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("abort_pending", 64'(sum0), 64'd136);
    dot_const(16'h0001, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("abort_after", 64'(sum0), 64'd16);

    // Reset mid dot with a result pending.
    dot_ramp(1'b0);
    for (int b = 0; b < 2; b++) cycle(1'b0, 1'b0, 1'b1, 1'b0, {4{16'h0009}});
    cycle(1'b1, 1'b0, 1'b1, 1'b0, {4{16'h0009}});
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("rst_valid", 64'(vld[0]), 64'd0);
    check("rst_sum", 64'(sum0), 64'd0);
    dot_const(16'h0003, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("rst_after", 64'(sum0), 64'd48);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            {pick(), pick(), pick(), pick()});
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
